// File: rtl/pbit_pkg.sv
// rtl/pbit_pkg.sv - shared p-bit constants and averager FSM state encoding
package pbit_pkg;

    localparam int PBIT_WIDTH = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_ACCUM  = 2'd2,
        S_DONE   = 2'd3
    } pbit_state_e;

endpackage

// File: rtl/pbit_bit_counter.sv
// rtl/pbit_bit_counter.sv - per-bit ones counter with clear and increment enable
module pbit_bit_counter #(
    parameter int CW = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] count
);

    // Clear wins over increment so the first accumulation edge starts from zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/pbit_sample_averager.sv
// rtl/pbit_sample_averager.sv - burn-in, windowed ones counting and majority readout for the p-bit adder
// Optional overflow counter built when PBIT_AVG_OVF_EN is defined.
module pbit_sample_averager
    import pbit_pkg::*;
#(
    parameter int WIDTH   = PBIT_WIDTH,
    parameter int LOG_WIN = 10,
    parameter int BURN_W  = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [BURN_W-1:0]                burn_in,
    input  logic [3:0]                       log_steps,
    input  logic [WIDTH-1:0]                 a_in,
    input  logic [WIDTH-1:0]                 b_in,
    input  logic [WIDTH-1:0]                 sum_in,
    input  logic                             ovf_in,
    output logic                             busy,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [WIDTH-1:0]                 a_avg,
    output logic [WIDTH-1:0]                 b_avg,
    output logic [WIDTH-1:0]                 sum_avg,
    output logic [3*WIDTH*(LOG_WIN+1)-1:0]   cnt_flat,
    output logic [LOG_WIN:0]                 ovf_cnt
);

    localparam int CW = LOG_WIN + 1;
    localparam int NB = 3 * WIDTH;

    pbit_state_e       state, state_nx;
    logic [BURN_W-1:0] burn_cnt;
    logic [CW-1:0]     step_cnt;
    logic [CW-1:0]     n_val;
    logic [CW-1:0]     half_n;
    logic [3:0]        log_n;
    logic [3:0]        log_clamp;
    logic              launch;
    logic              sample_en;
    logic              clear;
    logic [NB-1:0]     data;
    logic [NB-1:0]     maj;

    assign log_clamp = (int'(log_steps) > LOG_WIN) ? 4'(LOG_WIN) : log_steps;
    assign launch    = start && ((state == S_IDLE) || (state == S_DONE));
    assign n_val     = CW'(1) << log_n;
    assign half_n    = n_val >> 1;
    // ACCUM spends N edges sampling plus one closing edge, so DONE lands at k+burn_in+N+1.
    assign sample_en = (state == S_ACCUM) && (step_cnt != n_val);
    assign clear     = (state_nx == S_ACCUM) && (state != S_ACCUM);
    assign data      = {sum_in, b_in, a_in};

    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        res_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (launch) state_nx = (burn_in != '0) ? S_SETTLE : S_ACCUM;
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (burn_cnt == BURN_W'(1)) state_nx = S_ACCUM;
            end
            S_ACCUM: begin
                busy = 1'b1;
                if (step_cnt == n_val) state_nx = S_DONE;
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (launch)         state_nx = (burn_in != '0) ? S_SETTLE : S_ACCUM;
                else if (res_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            burn_cnt <= '0;
            step_cnt <= '0;
            log_n    <= '0;
        end else begin
            state <= state_nx;
            if (launch) begin
                burn_cnt <= burn_in;
                log_n    <= log_clamp;
            end else if (state == S_SETTLE) begin
                burn_cnt <= burn_cnt - BURN_W'(1);
            end
            if (clear) begin
                step_cnt <= '0;
            end else if (sample_en) begin
                step_cnt <= step_cnt + CW'(1);
            end
        end
    end

    for (genvar i = 0; i < NB; i++) begin : g_bit
        pbit_bit_counter #(.CW(CW)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clear (clear),
            .inc   (data[i] & sample_en),
            .count (cnt_flat[i*CW +: CW])
        );
        // Strict majority: an exact half-and-half split reads as 0.
        assign maj[i] = cnt_flat[i*CW +: CW] > half_n;
    end

    assign a_avg   = maj[WIDTH-1:0];
    assign b_avg   = maj[2*WIDTH-1:WIDTH];
    assign sum_avg = maj[3*WIDTH-1:2*WIDTH];

`ifdef PBIT_AVG_OVF_EN
    pbit_bit_counter #(.CW(CW)) u_ovf_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (ovf_in & sample_en),
        .count (ovf_cnt)
    );
`else
    logic unused_ovf;
    assign unused_ovf = ovf_in;
    assign ovf_cnt    = '0;
`endif

endmodule

// File: tb/tb_pbit_sample_averager.sv
// tb/tb_pbit_sample_averager.sv - directed self-checking bench for pbit_sample_averager
module tb_pbit_sample_averager;

    localparam int W  = 4;
    localparam int LW = 10;
    localparam int CW = LW + 1;
    localparam int BW = 8;
    localparam int FW = 3 * W * CW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [BW-1:0] burn_in;
    logic [3:0]    log_steps;
    logic [W-1:0]  a_in, b_in, sum_in;
    logic          ovf_in;
    logic          busy, res_valid, res_ready;
    logic [W-1:0]  a_avg, b_avg, sum_avg;
    logic [FW-1:0] cnt_flat;
    logic [CW-1:0] ovf_cnt;
    logic [FW-1:0] exp2;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pbit_sample_averager dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .burn_in   (burn_in),
        .log_steps (log_steps),
        .a_in      (a_in),
        .b_in      (b_in),
        .sum_in    (sum_in),
        .ovf_in    (ovf_in),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .a_avg     (a_avg),
        .b_avg     (b_avg),
        .sum_avg   (sum_avg),
        .cnt_flat  (cnt_flat),
        .ovf_cnt   (ovf_cnt)
    );

    function automatic logic [FW-1:0] const_counts(input logic [W-1:0] a, input logic [W-1:0] b,
                                                    input logic [W-1:0] s, input logic [CW-1:0] n);
        logic [FW-1:0] e;
        e = '0;
        for (int i = 0; i < W; i++) begin
            if (a[i]) e[i*CW +: CW]       = n;
            if (b[i]) e[(W+i)*CW +: CW]   = n;
            if (s[i]) e[(2*W+i)*CW +: CW] = n;
        end
        return e;
    endfunction

    task automatic drive_start(input logic [BW-1:0] bu, input logic [3:0] ls);
        @(negedge clk);
        start     = 1'b1;
        burn_in   = bu;
        log_steps = ls;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int bound, output int cyc);
        cyc = 0;
        while (!res_valid && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; res_ready = 1'b0; burn_in = '0; log_steps = '0;
        a_in = '1; b_in = '1; sum_in = '1; ovf_in = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, res_valid} !== 2'b00) begin
            miscompares++; $display("FAIL reset_flags got busy=%b valid=%b want 0 0", busy, res_valid);
        end
        vectors++;
        if (cnt_flat !== '0 || ovf_cnt !== '0 || {a_avg, b_avg, sum_avg} !== '0) begin
            miscompares++; $display("FAIL reset_outputs got cnt=%h ovf=%0d avg=%h want 0", cnt_flat, ovf_cnt, {a_avg, b_avg, sum_avg});
        end
        reset = 1'b1;
    endtask

    task automatic test_constant();
        int cyc;
        a_in = 4'd1; b_in = 4'd7; sum_in = 4'b1000; ovf_in = 1'b0;
        drive_start(8'd2, 4'd4);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++; $display("FAIL const_busy got %b want 1", busy);
        end
        wait_valid(100, cyc);
        vectors++;
        if (cyc != 19) begin
            miscompares++; $display("FAIL const_latency got %0d want 19", cyc);
        end
        vectors++;
        if ({sum_avg, b_avg, a_avg} !== {4'd8, 4'd7, 4'd1}) begin
            miscompares++; $display("FAIL const_avg got sum=%h b=%h a=%h want 8 7 1", sum_avg, b_avg, a_avg);
        end
        vectors++;
        if (cnt_flat !== const_counts(4'd1, 4'd7, 4'd8, 11'd16)) begin
            miscompares++; $display("FAIL const_counts got %h want %h", cnt_flat, const_counts(4'd1, 4'd7, 4'd8, 11'd16));
        end
        release_result();
    endtask

    task automatic test_tie();
        int cyc;
        a_in = 4'd5; b_in = 4'hF; sum_in = 4'd0;
        drive_start(8'd0, 4'd3);
        cyc = 0;
        while (!res_valid && cyc < 50) begin
            b_in = ~b_in;
            @(negedge clk);
            cyc++;
        end
        exp2 = const_counts(4'd5, 4'hF, 4'd0, 11'd8);
        for (int i = 0; i < W; i++) exp2[(W+i)*CW +: CW] = 11'd4;
        vectors++;
        if (cyc != 9) begin
            miscompares++; $display("FAIL tie_latency got %0d want 9", cyc);
        end
        vectors++;
        if (cnt_flat !== exp2) begin
            miscompares++; $display("FAIL tie_counts got %h want %h", cnt_flat, exp2);
        end
        vectors++;
        if ({b_avg, a_avg} !== {4'd0, 4'd5}) begin
            miscompares++; $display("FAIL tie_avg got b=%h a=%h want 0 5", b_avg, a_avg);
        end
    endtask

    task automatic test_hold();
        res_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            a_in = 4'($urandom); b_in = 4'($urandom); sum_in = 4'($urandom); ovf_in = ~ovf_in;
            @(negedge clk);
            vectors++;
            if (res_valid !== 1'b1 || cnt_flat !== exp2 || {sum_avg, b_avg, a_avg} !== {4'd0, 4'd0, 4'd5}) begin
                miscompares++;
                $display("FAIL hold_%0d got valid=%b cnt=%h avg=%h want 1 %h 005", i, res_valid, cnt_flat, {sum_avg, b_avg, a_avg}, exp2);
            end
        end
        release_result();
        vectors++;
        if ({busy, res_valid} !== 2'b00) begin
            miscompares++; $display("FAIL hold_release got busy=%b valid=%b want 0 0", busy, res_valid);
        end
    endtask

    task automatic test_majority();
        int cyc;
        logic [15:0]   seqv;
        logic [FW-1:0] e;
        seqv = 16'h89BF;
        b_in = '0; sum_in = '0;
        drive_start(8'd0, 4'd2);
        for (int i = 0; i < 4; i++) begin
            a_in = seqv[i*4 +: 4];
            @(negedge clk);
        end
        a_in = 4'hF;
        wait_valid(20, cyc);
        e = '0;
        e[0*CW +: CW] = 11'd3;
        e[1*CW +: CW] = 11'd2;
        e[2*CW +: CW] = 11'd1;
        e[3*CW +: CW] = 11'd4;
        vectors++;
        if (cyc != 1) begin
            miscompares++; $display("FAIL maj_latency got %0d want 1", cyc);
        end
        vectors++;
        if (cnt_flat !== e || a_avg !== 4'h9) begin
            miscompares++; $display("FAIL maj_result got cnt=%h a_avg=%h want %h 9", cnt_flat, a_avg, e);
        end
        release_result();
    endtask

    task automatic test_ovf();
        int cyc;
        logic [7:0] ov;
        logic [CW-1:0] exp_ovf;
        ov = 8'b0110_1011;
        a_in = '0; b_in = '0; sum_in = '0; ovf_in = 1'b0;
        drive_start(8'd0, 4'd3);
        for (int i = 0; i < 8; i++) begin
            ovf_in = ov[i];
            @(negedge clk);
        end
        ovf_in = 1'b1;
        wait_valid(20, cyc);
`ifdef PBIT_AVG_OVF_EN
        exp_ovf = 11'd5;
`else
        exp_ovf = 11'd0;
`endif
        vectors++;
        if (res_valid !== 1'b1 || ovf_cnt !== exp_ovf) begin
            miscompares++; $display("FAIL ovf_count got valid=%b ovf=%0d want 1 %0d", res_valid, ovf_cnt, exp_ovf);
        end
        release_result();
    endtask

    task automatic test_reset_mid();
        int cyc;
        a_in = 4'hF; b_in = 4'hF; sum_in = 4'hF; ovf_in = 1'b1;
        drive_start(8'd0, 4'd4);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, res_valid} !== 2'b00 || cnt_flat !== '0 || ovf_cnt !== '0 || {a_avg, b_avg, sum_avg} !== '0) begin
            miscompares++; $display("FAIL mid_reset got busy=%b valid=%b cnt=%h want 0 0 0", busy, res_valid, cnt_flat);
        end
        reset = 1'b1;
        a_in = 4'hA; b_in = 4'hC; sum_in = 4'h3;
        drive_start(8'd1, 4'd1);
        wait_valid(20, cyc);
        vectors++;
        if (cyc != 4) begin
            miscompares++; $display("FAIL post_reset_latency got %0d want 4", cyc);
        end
        vectors++;
        if (cnt_flat !== const_counts(4'hA, 4'hC, 4'h3, 11'd2) || {sum_avg, b_avg, a_avg} !== 12'h3CA) begin
            miscompares++; $display("FAIL post_reset_result got cnt=%h avg=%h want %h 3ca", cnt_flat, {sum_avg, b_avg, a_avg}, const_counts(4'hA, 4'hC, 4'h3, 11'd2));
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(negedge clk);
        start = 1'b1; burn_in = 8'd0; log_steps = 4'd0; res_ready = 1'b0;
        a_in = 4'd6; b_in = 4'd9; sum_in = 4'd0;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if ({busy, res_valid} !== 2'b10) begin
            miscompares++; $display("FAIL b2b_restart got busy=%b valid=%b want 1 0", busy, res_valid);
        end
        wait_valid(10, cyc);
        vectors++;
        if (cyc != 2) begin
            miscompares++; $display("FAIL b2b_latency got %0d want 2", cyc);
        end
        vectors++;
        if (cnt_flat !== const_counts(4'd6, 4'd9, 4'd0, 11'd1) || {sum_avg, b_avg, a_avg} !== 12'h096) begin
            miscompares++; $display("FAIL b2b_n1_result got cnt=%h avg=%h want %h 096", cnt_flat, {sum_avg, b_avg, a_avg}, const_counts(4'd6, 4'd9, 4'd0, 11'd1));
        end
        release_result();
    endtask

    task automatic test_max_window();
        int cyc;
        a_in = 4'hF; b_in = 4'hF; sum_in = 4'hF;
        drive_start(8'd0, 4'd15);
        wait_valid(1200, cyc);
        vectors++;
        if (cyc != 1025) begin
            miscompares++; $display("FAIL max_latency got %0d want 1025", cyc);
        end
        vectors++;
        if (cnt_flat !== const_counts(4'hF, 4'hF, 4'hF, 11'd1024) || {sum_avg, b_avg, a_avg} !== 12'hFFF) begin
            miscompares++; $display("FAIL max_result got cnt=%h avg=%h want all 1024 fff", cnt_flat, {sum_avg, b_avg, a_avg});
        end
        release_result();
    endtask

    initial begin
        test_reset();
        test_constant();
        test_tie();
        test_hold();
        test_majority();
        test_ovf();
        test_reset_mid();
        test_back_to_back();
        test_max_window();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
